nios2_control_led_pulse_pio: RTL and testbench
==============================================

Name: nios2_control_led_pulse_pio

Overview:
Avalon-MM slave output PIO for the Nios II control subsystem; drives the board LEDs, the output-side counterpart of the button input PIO. Supports direct write, atomic bit set/clear, and a hardware-timed one-shot pulse. During the pulse, selected bits are inverted for a programmed number of clk cycles, then restored. A sticky done flag and a maskable irq are raised on pulse completion.

Parameters:
WIDTH, 4, number of output bits (1..32)
PULSE_CNT_W, 16, width of pulse length register/counter (1..32)
RESET_VALUE, 0, reset value of the data register

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, valid with chipselect
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  WIDTH  LED drive
irq  output  1  pulse-done interrupt, level

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state is reset asynchronously and clocked on the clk rising edge.
- Write strobe: wr = chipselect & ~write_n. No wait states.
- Register map (word addresses):
  - 0 DATA, RW: data_reg[WIDTH-1:0].
  - 1 PULSE_LEN, RW: len_reg[PULSE_CNT_W-1:0].
  - 2 IRQ_MASK, RW: bit0 only.
  - 3 STATUS: bit0 busy (RO), bit1 done. Any write clears done.
  - 4 OUTSET, WO: data_reg |= writedata[WIDTH-1:0].
  - 5 OUTCLEAR, WO: data_reg &= ~writedata[WIDTH-1:0].
  - 6 PULSE, WO: start a pulse with mask = writedata[WIDTH-1:0].
  - 7: reserved. Writes are ignored and reads return 0.
- Write-only addresses (4, 5, 6) read as 0. Unused upper bits read as 0.
- readdata is registered: on every clk edge, readdata <= mux(address), regardless of chipselect. This gives one-cycle read latency.
- out_port = data_reg ^ pulse_mask. It is driven from registers only, so it is glitch-free. A write takes effect on out_port at the edge that samples it.
- Pulse FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE when wr to address 6, mask != 0 and len_reg != 0. On that edge: pulse_mask <= mask, cnt <= len_reg.
  - In IDLE, a PULSE write with mask == 0 or len_reg == 0 is ignored: no state change, done is not set.
  - In ACTIVE, cnt decrements each cycle. On the edge where cnt == 1: go to IDLE, pulse_mask <= 0, done <= 1.
  - Result: out_port is inverted for exactly len_reg cycles.
  - A PULSE write while ACTIVE is ignored; the pulse is not restarted.
  - A PULSE_LEN write while ACTIVE does not affect the running cnt; it applies to the next pulse.
  - DATA, OUTSET and OUTCLEAR writes during ACTIVE update data_reg immediately, and out_port remains data_reg ^ pulse_mask.
- busy = (state == ACTIVE).
- irq = done & irq_mask[0].
- Simultaneous events: if a STATUS write and pulse completion occur on the same edge, done ends at 1 (set wins, event not lost).
- Reset values: data_reg = RESET_VALUE, so out_port = RESET_VALUE. len_reg, irq_mask, pulse_mask, cnt and done = 0. State = IDLE. readdata = 0. irq = 0.
- Reset asserted mid-pulse: the pulse is aborted immediately (asynchronous), out_port returns to RESET_VALUE, and done is not set.
- Counter wraparound is impossible: the counter only loads nonzero values and stops at 1.
- Maximum pulse length: 2^PULSE_CNT_W - 1 cycles.

Test Plan:
1. Reset with RESET_VALUE=0 -> out_port=0, readdata=0, irq=0. Write DATA=0x5 -> out_port=0x5 after the next edge. Read addr 0 -> readdata=0x5 one cycle after address is presented.
2. DATA=0x5, OUTSET 0x2 -> 0x7. OUTCLEAR 0x4 -> 0x3. Read addr 4 -> 0.
3. DATA=0x3, PULSE_LEN=10, PULSE mask 0xC -> out_port=0xF for exactly 10 cycles, then 0x3. busy=1 during those 10 cycles. done=1 at the restore edge. irq=0 with mask 0, irq=1 after IRQ_MASK=1. Write STATUS -> done=0, irq=0.
4. PULSE_LEN=0, PULSE 0x1 -> no change, busy=0, done=0. PULSE_LEN=5, PULSE 0x0 -> ignored.
5. PULSE_LEN=8, PULSE 0x1. At cycle 3, PULSE 0x2 and PULSE_LEN=20 -> only bit0 inverted, pulse ends after 8 cycles. Next pulse lasts 20 cycles. Issue a STATUS write on the completion edge -> done reads 1.
6. Mid-pulse, DATA=0x8 -> out_port=0x9 during the pulse, 0x8 after. Assert reset_n low mid-pulse -> out_port=0 immediately, busy=0, done=0.

Source files
------------

// File: rtl/nios2_control_led_pulse_pio_if.sv
// Avalon-MM slave bus bundle for the LED pulse PIO.
// Addressing is by word; reads have a fixed one-cycle latency.
interface nios2_control_led_pulse_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );
endinterface

// File: rtl/nios2_control_led_pulse_pio.sv
// LED output PIO: direct write, atomic set/clear, and a timed one-shot
// inversion pulse with a sticky done flag and a maskable level irq.
module nios2_control_led_pulse_pio #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PULSE_CNT_W = 16,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nios2_control_led_pulse_pio_if.slave bus,
    output logic [WIDTH-1:0]             out_port,
    output logic                         irq
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       data_reg;
    logic [WIDTH-1:0]       pulse_mask;
    logic [PULSE_CNT_W-1:0] len_reg;
    logic [PULSE_CNT_W-1:0] cnt;
    logic                   irq_mask;
    logic                   done;
    logic                   busy;
    logic                   start;
    logic                   finish;
    logic                   wr;
    logic [WIDTH-1:0]       wmask;
    logic [31:0]            rd_mux;

    assign wr    = bus.chipselect & ~bus.write_n;
    assign wmask = bus.writedata[WIDTH-1:0];

    // A start needs a nonzero mask and length, and is only taken from IDLE.
    assign start = wr && (bus.address == 3'd6) && (state == IDLE) &&
                   (wmask != '0) && (len_reg != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ACTIVE;
            ACTIVE:  if (cnt == PULSE_CNT_W'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ACTIVE);
        finish = (state == ACTIVE) && (cnt == PULSE_CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= WIDTH'(RESET_VALUE);
            len_reg  <= '0;
            irq_mask <= 1'b0;
        end else if (wr) begin
            case (bus.address)
                3'd0:    data_reg <= wmask;
                3'd1:    len_reg  <= bus.writedata[PULSE_CNT_W-1:0];
                3'd2:    irq_mask <= bus.writedata[0];
                3'd4:    data_reg <= data_reg | wmask;
                3'd5:    data_reg <= data_reg & ~wmask;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask <= '0;
            cnt        <= '0;
        end else if (start) begin
            pulse_mask <= wmask;
            cnt        <= len_reg;
        end else if (busy) begin
            cnt <= cnt - PULSE_CNT_W'(1);
            if (finish) pulse_mask <= '0;
        end
    end

    // Completion beats a same-edge STATUS write so the event is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           done <= 1'b0;
        else if (finish)                        done <= 1'b1;
        else if (wr && bus.address == 3'd3)     done <= 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux[WIDTH-1:0]       = data_reg;
            3'd1:    rd_mux[PULSE_CNT_W-1:0] = len_reg;
            3'd2:    rd_mux[0]               = irq_mask;
            3'd3:    rd_mux[1:0]             = {done, busy};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign out_port = data_reg ^ pulse_mask;
    assign irq      = done & irq_mask;
endmodule

// File: tb/tb_nios2_control_led_pulse_pio.sv
// Directed bench for the LED pulse PIO: register access, set/clear,
// pulse timing, ignored starts, same-edge done handling and async reset.
module tb_nios2_control_led_pulse_pio;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] out_port;
    logic       irq;
    int         n_chk = 0;
    int         n_err = 0;
    logic [31:0] rd;
    int          n;

    nios2_control_led_pulse_pio_if bus ();

    nios2_control_led_pulse_pio #(
        .WIDTH(4), .PULSE_CNT_W(16), .RESET_VALUE(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .out_port(out_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        d = bus.readdata;
    endtask

    // Counts further edges on which out_port still shows the inverted value.
    task automatic count_on(input logic [3:0] v, inout int cnt_o);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_port == v) cnt_o++;
            else break;
        end
    endtask

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #1;
        chk("rst_out", 32'(out_port), 0);
        chk("rst_rd", bus.readdata, 0);
        chk("rst_irq", 32'(irq), 0);
        #20 reset_n = 1'b1;

        bus_wr(3'd0, 32'h5);
        chk("data_out", 32'(out_port), 32'h5);
        bus_rd(3'd0, rd);
        chk("data_rd", rd, 32'h5);

        bus_wr(3'd4, 32'h2);
        chk("outset", 32'(out_port), 32'h7);
        bus_wr(3'd5, 32'h4);
        chk("outclr", 32'(out_port), 32'h3);
        bus_rd(3'd4, rd);
        chk("rd_wo", rd, 0);
        bus_wr(3'd7, 32'hF);
        bus_rd(3'd7, rd);
        chk("rd_rsv", rd, 0);
        chk("rsv_out", 32'(out_port), 32'h3);

        bus_wr(3'd1, 32'd10);
        bus_rd(3'd1, rd);
        chk("len_rd", rd, 32'd10);
        bus_wr(3'd6, 32'hC);
        n = (out_port == 4'hF) ? 1 : 0;
        count_on(4'hF, n);
        chk("p10_len", 32'(n), 10);
        chk("p10_rest", 32'(out_port), 32'h3);
        chk("irq_m0", 32'(irq), 0);
        bus_rd(3'd3, rd);
        chk("st_done", rd, 32'h2);
        bus_wr(3'd2, 32'h1);
        chk("irq_m1", 32'(irq), 1);
        bus_wr(3'd3, 32'h0);
        chk("irq_clr", 32'(irq), 0);
        bus_rd(3'd3, rd);
        chk("st_clr", rd, 0);

        bus_wr(3'd1, 32'd0);
        bus_wr(3'd6, 32'h1);
        chk("len0_out", 32'(out_port), 32'h3);
        bus_rd(3'd3, rd);
        chk("len0_st", rd, 0);
        bus_wr(3'd1, 32'd5);
        bus_wr(3'd6, 32'h0);
        chk("m0_out", 32'(out_port), 32'h3);
        bus_rd(3'd3, rd);
        chk("m0_st", rd, 0);

        bus_wr(3'd1, 32'd8);
        bus_wr(3'd6, 32'h1);
        n = (out_port == 4'h2) ? 1 : 0;
        bus_wr(3'd6, 32'h2);
        if (out_port == 4'h2) n++;
        bus_wr(3'd1, 32'd20);
        if (out_port == 4'h2) n++;
        chk("nrst_out", 32'(out_port), 32'h2);
        count_on(4'h2, n);
        chk("p8_len", 32'(n), 8);
        chk("p8_rest", 32'(out_port), 32'h3);
        bus_wr(3'd3, 32'h0);

        bus_wr(3'd6, 32'h1);
        n = (out_port == 4'h2) ? 1 : 0;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_port == 4'h2) n++;
        end
        chk("p20_len", 32'(n), 20);
        bus_wr(3'd3, 32'h0);
        chk("p20_rest", 32'(out_port), 32'h3);
        bus_rd(3'd3, rd);
        chk("same_edge", rd, 32'h2);
        chk("same_irq", 32'(irq), 1);

        bus_wr(3'd3, 32'h0);
        bus_wr(3'd1, 32'd10);
        bus_wr(3'd6, 32'h1);
        bus_wr(3'd0, 32'h8);
        chk("mid_data", 32'(out_port), 32'h9);
        bus_rd(3'd3, rd);
        chk("st_busy", rd, 32'h1);
        n = 0;
        count_on(4'h9, n);
        chk("mid_rest", 32'(out_port), 32'h8);

        bus_wr(3'd3, 32'h0);
        bus_wr(3'd6, 32'h3);
        chk("pre_rst", 32'(out_port), 32'hB);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_out", 32'(out_port), 0);
        chk("arst_irq", 32'(irq), 0);
        #10 reset_n = 1'b1;
        bus_rd(3'd3, rd);
        chk("arst_st", rd, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("arst_hold", 32'(out_port), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
